uart_boot_ctrl: RTL

Parametrised UART boot controller; next generation of the pipeline's program loader. Parses a framed command protocol from the UART receiver, writes words into instruction memory with checksum verification, reads memory back for host-side verify, and holds the RISC-V pipeline stalled until the host issues a GO command. Sits between the UART core (`rx_Data`/`rx_ready`, `tx_Data`/`tx_Start`/`tx_busy`) and the instruction memory write/read port.

---
 rtl/boot_pkg.sv | 29 ++
 rtl/uart_tx_handshake.sv | 32 +++
 rtl/uart_boot_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared constants and state encoding for the UART boot loader: command
// codes, response bytes, header length and the controller state enum.
package boot_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_READ = 8'h52;
   localparam logic [7:0] CMD_GO   = 8'h47;

   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   // addr[15:0] + len[15:0], little-endian
   localparam int HDR_BYTES = 4;
   localparam int HDR_CNT_W = $clog2(HDR_BYTES);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CSUM,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_SEND,
      ST_RD_CSUM,
      ST_RESP,
      ST_GO
   } state_t;

endpackage

// File: rtl/uart_tx_handshake.sv
// Single-byte request/accept front end for the UART transmitter. Owns the
// tx_start / tx_busy spacing rule so the controller only has to hold req.
module uart_tx_handshake (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic [7:0] req_data,
   output logic       accept,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data
);

   logic holdoff;

   // tx_busy is not trusted in the strobe cycle nor in the cycle after it
   assign accept = req && !tx_start && !holdoff && !tx_busy;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         tx_start <= 1'b0;
         holdoff  <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_start <= accept;
         holdoff  <= tx_start;
         if (accept) tx_data <= req_data;
      end
   end

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART boot controller: parses L/R/G frames, loads and reads back instruction
// memory with checksums, and holds the pipeline stalled until GO.
module uart_boot_ctrl
   import boot_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_pro,
   output logic              core_reset
);

   localparam int BYTES = DATA_W / 8;
   localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t               state, state_next;
   logic [HDR_CNT_W-1:0] hdr_cnt;
   logic                 is_read;
   logic                 go_after;
   logic [15:0]          addr_field;
   logic [7:0]           len_lo;
   logic [15:0]          words_left;
   logic [BI_W-1:0]      byte_idx;
   logic [DATA_W-1:0]    word_buf;
   logic [DATA_W-1:0]    word_next;
   logic [7:0]           csum;
   logic [7:0]           resp_byte;
   logic [TO_W-1:0]      to_cnt;

   logic                 in_frame, to_hit;
   logic                 last_byte, last_word, hdr_last, hdr_bad;
   logic [15:0]          hdr_len;
   logic [16:0]          hdr_end;
   logic                 tx_req, tx_accept;
   logic [7:0]           tx_req_data;

   assign last_byte = (byte_idx == BI_W'(BYTES - 1));
   assign last_word = (words_left == 16'd1);
   assign hdr_last  = (hdr_cnt == HDR_CNT_W'(HDR_BYTES - 1));

   // Header is judged while its final byte is still on rx_data
   assign hdr_len = {rx_data, len_lo};
   assign hdr_end = {1'b0, addr_field} + {1'b0, hdr_len} - 17'd1;
   assign hdr_bad = (hdr_len == 16'd0)
                 || ((addr_field >> ADDR_W) != 16'd0)
                 || ((hdr_end >> ADDR_W) != 17'd0);

   assign word_next = (word_buf >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));

   assign in_frame = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
   assign to_hit   = in_frame && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   uart_tx_handshake u_tx (
      .clk      (clk),
      .reset    (reset),
      .req      (tx_req),
      .req_data (tx_req_data),
      .accept   (tx_accept),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves a latch behind.
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_LOAD || rx_data == CMD_READ) state_next = ST_HDR;
               else                                            state_next = ST_RESP;
            end
         end
         ST_HDR: begin
            if (rx_valid && hdr_last)
               state_next = hdr_bad ? ST_RESP : (is_read ? ST_RD_REQ : ST_DATA);
            else if (to_hit)
               state_next = ST_RESP;
         end
         ST_DATA: begin
            if (rx_valid && last_byte && last_word) state_next = ST_CSUM;
            else if (to_hit)                        state_next = ST_RESP;
         end
         ST_CSUM:    if (rx_valid || to_hit) state_next = ST_RESP;
         ST_RD_REQ:  state_next = ST_RD_WAIT;
         ST_RD_WAIT: state_next = ST_RD_SEND;
         ST_RD_SEND: begin
            if (tx_accept && last_byte) state_next = last_word ? ST_RD_CSUM : ST_RD_REQ;
         end
         ST_RD_CSUM: if (tx_accept) state_next = ST_IDLE;
         ST_RESP:    if (tx_accept) state_next = go_after ? ST_GO : ST_IDLE;
         ST_GO:      state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_req      = 1'b0;
      tx_req_data = resp_byte;
      case (state)
         ST_RD_SEND: begin
            tx_req      = 1'b1;
            tx_req_data = word_buf[7:0];
         end
         ST_RD_CSUM: begin
            tx_req      = 1'b1;
            tx_req_data = csum;
         end
         ST_RESP: tx_req = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || rx_valid || !in_frame) to_cnt <= '0;
      else if (!to_hit)                   to_cnt <= to_cnt + TO_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_cnt    <= '0;
         is_read    <= 1'b0;
         go_after   <= 1'b0;
         addr_field <= 16'd0;
         len_lo     <= 8'd0;
         words_left <= 16'd0;
         byte_idx   <= '0;
         word_buf   <= '0;
         csum       <= 8'd0;
         resp_byte  <= 8'd0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         stall_pro  <= 1'b1;
         core_reset <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         mem_re     <= (state_next == ST_RD_REQ);
         core_reset <= (state == ST_GO);
         if (state == ST_GO) stall_pro <= 1'b0;
         // A write seen while still in DATA was not the last word: advance
         if (mem_we && state == ST_DATA) mem_addr <= mem_addr + ADDR_W'(1);

         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  hdr_cnt  <= '0;
                  go_after <= (rx_data == CMD_GO);
                  case (rx_data)
                     CMD_LOAD: begin
                        is_read   <= 1'b0;
                        stall_pro <= 1'b1;
                     end
                     CMD_READ: begin
                        is_read   <= 1'b1;
                        stall_pro <= 1'b1;
                     end
                     CMD_GO:  resp_byte <= RSP_ACK;
                     default: resp_byte <= RSP_NAK;
                  endcase
               end
            end
            ST_HDR: begin
               resp_byte <= RSP_NAK;
               if (rx_valid) begin
                  hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
                  case (hdr_cnt)
                     HDR_CNT_W'(0): addr_field[7:0]  <= rx_data;
                     HDR_CNT_W'(1): addr_field[15:8] <= rx_data;
                     HDR_CNT_W'(2): len_lo           <= rx_data;
                     default: begin
                        words_left <= hdr_len;
                        mem_addr   <= addr_field[ADDR_W-1:0];
                        byte_idx   <= '0;
                        csum       <= 8'd0;
                     end
                  endcase
               end
            end
            ST_DATA: begin
               resp_byte <= RSP_NAK;
               if (rx_valid) begin
                  csum     <= csum + rx_data;
                  word_buf <= word_next;
                  byte_idx <= last_byte ? '0 : byte_idx + BI_W'(1);
                  if (last_byte) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= word_next;
                     if (!last_word) words_left <= words_left - 16'd1;
                  end
               end
            end
            ST_CSUM: resp_byte <= (rx_valid && rx_data == csum) ? RSP_ACK : RSP_NAK;
            ST_RD_WAIT: word_buf <= mem_rdata;
            ST_RD_SEND: begin
               if (tx_accept) begin
                  csum     <= csum + word_buf[7:0];
                  word_buf <= word_buf >> 8;
                  byte_idx <= last_byte ? '0 : byte_idx + BI_W'(1);
                  if (last_byte && !last_word) begin
                     words_left <= words_left - 16'd1;
                     mem_addr   <= mem_addr + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
